song_reader: RTL and testbench

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader.sv | 88 ++++++++
 tb/tb_song_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: steps through a 32-note song in ROM and hands each note to the note player
// Ports: clk, reset (sync, active-high); play (level run/pause); song (song select);
//   note_done (player finished current note); rom_addr/rom_data (1-cycle-latency ROM);
//   note_to_load/duration_to_load (registered note word); load_new_note, song_done (pulses)
module song_reader #(
  parameter int NOTE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [1:0]           song,
  input  logic                 note_done,
  output logic [NOTE_BITS+1:0] rom_addr,
  input  logic [11:0]          rom_data,
  output logic [5:0]           note_to_load,
  output logic [5:0]           duration_to_load,
  output logic                 load_new_note,
  output logic                 song_done
);
  typedef enum logic [2:0] {IDLE, RD, CHK, LOAD, WAIT} state_t;
  state_t               r_state;
  logic [1:0]           r_song;
  logic [NOTE_BITS-1:0] r_idx;
  logic                 r_pend;
  assign rom_addr = {r_song, r_idx};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_song           <= song;
      r_idx            <= '0;
      r_pend           <= 1'b0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      load_new_note <= 1'b0;
      song_done     <= 1'b0;
      // a new song selection restarts from note 0, overriding anything else this cycle
      if (r_state != IDLE && song != r_song) begin
        r_song  <= song;
        r_idx   <= '0;
        r_pend  <= 1'b0;
        r_state <= RD;
      end else begin
        case (r_state)
          IDLE: begin
            r_song <= song;
            r_idx  <= '0;
            r_pend <= 1'b0;
            if (play) r_state <= RD;
          end
          RD: if (play) r_state <= CHK;
          CHK: if (play) begin
            if (rom_data[5:0] == 6'd0) begin
              song_done <= 1'b1;
              r_state   <= IDLE;
            end else begin
              note_to_load     <= rom_data[11:6];
              duration_to_load <= rom_data[5:0];
              r_state          <= LOAD;
            end
          end
          LOAD: if (play) begin
            load_new_note <= 1'b1;
            r_state       <= WAIT;
          end
          WAIT: begin
            // a note_done seen while paused is remembered until play returns
            if (!play) r_pend <= r_pend | note_done;
            else if (note_done || r_pend) begin
              r_pend <= 1'b0;
              if (&r_idx) begin
                song_done <= 1'b1;
                r_idx     <= '0;
                r_state   <= IDLE;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= RD;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed self-checking bench for song_reader
module tb_song_reader;
  logic        clk = 1'b0;
  logic        reset, play, note_done;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load, duration_to_load;
  logic        load_new_note, song_done;
  logic [11:0] rom [128];
  int          tests = 0, fails = 0;
  int          n_ld = 0, n_sd = 0, n_both = 0;
  song_reader #(.NOTE_BITS(5)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note), .song_done(song_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  task automatic step();
    @(posedge clk);
    #1;
    if (load_new_note) n_ld++;
    if (song_done) n_sd++;
    if (load_new_note && song_done) n_both++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
  endtask
  task automatic wait_load(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      step();
      if (load_new_note) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask
  initial begin
    int ld0, sd0;
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    for (int i = 0; i < 32; i++) rom[i] = {6'(i + 1), 6'(i + 1)};
    rom[32] = {6'd12, 6'd4};
    rom[33] = {6'd20, 6'd3};
    rom[34] = {6'd7, 6'd9};
    rom[35] = {6'd50, 6'd0};
    rom[64] = {6'd33, 6'd5};
    rom[65] = {6'd40, 6'd6};
    reset = 1'b1; play = 1'b0; song = 2'd1; note_done = 1'b0;
    step();
    step();
    chk("rst_load", 32'(load_new_note), 32'd0);
    chk("rst_done", 32'(song_done), 32'd0);
    chk("rst_note", 32'(note_to_load), 32'd0);
    chk("rst_dur", 32'(duration_to_load), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'h20);
    reset = 1'b0;
    play = 1'b1;
    step();
    chk("basic_addr", 32'(rom_addr), 32'h20);
    ld0 = n_ld;
    step();
    step();
    chk("basic_early", 32'(n_ld - ld0), 32'd0);
    step();
    chk("basic_load", 32'(load_new_note), 32'd1);
    chk("basic_note", 32'(note_to_load), 32'd12);
    chk("basic_dur", 32'(duration_to_load), 32'd4);
    step();
    chk("basic_pulse1", 32'(load_new_note), 32'd0);
    pulse();
    chk("seq_addr1", 32'(rom_addr), 32'h21);
    step();
    step();
    chk("seq_early", 32'(load_new_note), 32'd0);
    step();
    chk("seq_load2", 32'(load_new_note), 32'd1);
    chk("seq_note2", 32'(note_to_load), 32'd20);
    chk("seq_dur2", 32'(duration_to_load), 32'd3);
    pulse();
    wait_load("seq_wait3");
    chk("seq_note3", 32'(note_to_load), 32'd7);
    chk("seq_dur3", 32'(duration_to_load), 32'd9);
    ld0 = n_ld;
    sd0 = n_sd;
    pulse();
    step();
    step();
    chk("seq_done", 32'(song_done), 32'd1);
    play = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("seq_done_once", 32'(n_sd - sd0), 32'd1);
    chk("seq_no_load4", 32'(n_ld - ld0), 32'd0);
    chk("seq_idle_addr", 32'(rom_addr), 32'h20);
    song = 2'd0;
    step();
    play = 1'b1;
    ld0 = n_ld;
    for (int i = 0; i < 32; i++) begin
      wait_load("full_wait");
      chk("full_note", 32'(note_to_load), 32'(i + 1));
      pulse();
    end
    chk("full_done", 32'(song_done), 32'd1);
    chk("full_addr0", 32'(rom_addr), 32'h00);
    play = 1'b0;
    step();
    chk("full_loads", 32'(n_ld - ld0), 32'd32);
    song = 2'd1;
    step();
    play = 1'b1;
    wait_load("pause_first");
    chk("pause_first_note", 32'(note_to_load), 32'd12);
    play = 1'b0;
    step();
    ld0 = n_ld;
    pulse();
    for (int i = 0; i < 5; i++) step();
    chk("pause_no_load", 32'(n_ld - ld0), 32'd0);
    play = 1'b1;
    step();
    step();
    step();
    chk("pause_early", 32'(n_ld - ld0), 32'd0);
    step();
    chk("pause_resume", 32'(load_new_note), 32'd1);
    chk("pause_note", 32'(note_to_load), 32'd20);
    pulse();
    step();
    step();
    play = 1'b0;
    ld0 = n_ld;
    for (int i = 0; i < 4; i++) step();
    chk("load_hold", 32'(n_ld - ld0), 32'd0);
    play = 1'b1;
    step();
    chk("load_release", 32'(load_new_note), 32'd1);
    chk("load_note", 32'(note_to_load), 32'd7);
    rom[35] = {6'd8, 6'd1};
    rom[36] = {6'd9, 6'd1};
    rom[37] = {6'd10, 6'd1};
    for (int i = 0; i < 3; i++) begin
      pulse();
      wait_load("chg_wait");
      chk("chg_note", 32'(note_to_load), 32'(8 + i));
    end
    sd0 = n_sd;
    song = 2'd2;
    step();
    chk("chg_addr", 32'(rom_addr), 32'h40);
    wait_load("chg_first");
    chk("chg_first_note", 32'(note_to_load), 32'd33);
    chk("chg_first_dur", 32'(duration_to_load), 32'd5);
    chk("chg_no_done", 32'(n_sd - sd0), 32'd0);
    pulse();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_load", 32'(load_new_note), 32'd0);
    chk("mid_rst_note", 32'(note_to_load), 32'd0);
    chk("mid_rst_dur", 32'(duration_to_load), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'h40);
    wait_load("mid_rst_restart");
    chk("mid_rst_first", 32'(note_to_load), 32'd33);
    chk("mid_rst_no_done", 32'(n_sd - sd0), 32'd0);
    chk("never_both", 32'(n_both), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
